// File: rtl/gobang_pkg.sv
// Shared board geometry, result encodings and controller state type for the gobang game logic.
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_BLACK = 2'b01;
    localparam logic [1:0] WIN_WHITE = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

endpackage

// File: rtl/cell_index.sv
// Flattens a (row, col) board coordinate into the linear cell index and flags whether it lies on the board.
module cell_index
    import gobang_pkg::*;
#(
    parameter int N = BOARD_N
) (
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] idx,
    output logic       in_range
);

    // An off-board coordinate still yields an index below 256; callers must qualify it with in_range.
    assign idx      = 8'(row) * 8'(N) + 8'(col);
    assign in_range = (int'(row) < N) && (int'(col) < N);

endmodule

// File: rtl/board_state_ctrl.sv
// Gobang board and turn controller: validates moves, keeps both occupancy maps and
// sequences the external win check after every placed stone.
module board_state_ctrl #(
    parameter int BOARD_N = gobang_pkg::BOARD_N,
    parameter int CELLS   = gobang_pkg::CELLS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [3:0]       move_row,
    input  logic [3:0]       move_col,
    output logic             move_ready,
    output logic             move_ack,
    output logic             move_reject,
    output logic [3:0]       chk_row,
    output logic [3:0]       chk_col,
    output logic [CELLS-1:0] chk_board,
    input  logic             chk_win,
    output logic [CELLS-1:0] board_black,
    output logic [CELLS-1:0] board_white,
    output logic             turn,
    output logic [7:0]       move_count,
    output logic             game_over,
    output logic [1:0]       winner
);

    gobang_pkg::state_t state;

    logic [7:0]       idx;
    logic             in_range;
    logic [CELLS-1:0] occupied_map;
    logic             occupied;
    logic             legal;
    logic             handshake;
    logic             show_white;

    cell_index #(
        .N(BOARD_N)
    ) u_cell_index (
        .row      (move_row),
        .col      (move_col),
        .idx      (idx),
        .in_range (in_range)
    );

    assign occupied_map = board_black | board_white;
    assign occupied     = in_range && occupied_map[idx];
    assign legal        = in_range && !occupied;

    assign move_ready = (state == gobang_pkg::IDLE) && !new_game;
    assign handshake  = move_valid && move_ready;

    // Turn only flips when leaving CHECK, so in IDLE the previous mover is the opposite side.
    assign show_white = (state == gobang_pkg::IDLE) ? (!turn && (move_count != 8'd0)) : turn;
    assign chk_board  = show_white ? board_white : board_black;

    always_ff @(posedge clk) begin
        move_ack    <= 1'b0;
        move_reject <= 1'b0;
        if (rst || new_game) begin
            state       <= gobang_pkg::IDLE;
            board_black <= '0;
            board_white <= '0;
            turn        <= 1'b0;
            move_count  <= 8'd0;
            chk_row     <= 4'd0;
            chk_col     <= 4'd0;
            game_over   <= 1'b0;
            winner      <= gobang_pkg::WIN_NONE;
        end else begin
            case (state)
                gobang_pkg::IDLE: begin
                    if (handshake) begin
                        if (legal) begin
                            if (turn) begin
                                board_white[idx] <= 1'b1;
                            end else begin
                                board_black[idx] <= 1'b1;
                            end
                            chk_row    <= move_row;
                            chk_col    <= move_col;
                            move_count <= move_count + 8'd1;
                            move_ack   <= 1'b1;
                            state      <= gobang_pkg::CHECK;
                        end else begin
                            move_reject <= 1'b1;
                        end
                    end
                end
                gobang_pkg::CHECK: begin
                    // A win on the final cell outranks the draw.
                    if (chk_win) begin
                        state     <= gobang_pkg::OVER;
                        game_over <= 1'b1;
                        winner    <= turn ? gobang_pkg::WIN_WHITE : gobang_pkg::WIN_BLACK;
                    end else if (move_count == 8'(CELLS)) begin
                        state     <= gobang_pkg::OVER;
                        game_over <= 1'b1;
                        winner    <= gobang_pkg::WIN_DRAW;
                    end else begin
                        turn  <= !turn;
                        state <= gobang_pkg::IDLE;
                    end
                end
                gobang_pkg::OVER: begin
                    state <= gobang_pkg::OVER;
                end
                default: begin
                    state <= gobang_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench for board_state_ctrl: directed vector table, corner-case sequences and a
// randomized run against a cell-array game model that also plays the role of the win checkers.
module tb_board_state_ctrl;

    localparam int N     = 15;
    localparam int CELLS = 225;

    logic             clk = 1'b0;
    logic             rst;
    logic             new_game;
    logic             move_valid;
    logic [3:0]       move_row;
    logic [3:0]       move_col;
    logic             move_ready;
    logic             move_ack;
    logic             move_reject;
    logic [3:0]       chk_row;
    logic [3:0]       chk_col;
    logic [CELLS-1:0] chk_board;
    logic             chk_win;
    logic [CELLS-1:0] board_black;
    logic [CELLS-1:0] board_white;
    logic             turn;
    logic [7:0]       move_count;
    logic             game_over;
    logic [1:0]       winner;

    board_state_ctrl #(
        .BOARD_N(N),
        .CELLS  (CELLS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_row    (move_row),
        .move_col    (move_col),
        .move_ready  (move_ready),
        .move_ack    (move_ack),
        .move_reject (move_reject),
        .chk_row     (chk_row),
        .chk_col     (chk_col),
        .chk_board   (chk_board),
        .chk_win     (chk_win),
        .board_black (board_black),
        .board_white (board_white),
        .turn        (turn),
        .move_count  (move_count),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Game model: cell owner 0 empty, 1 black, 2 white.
    int occ[CELLS];
    int m_turn, m_count, m_over, m_winner, m_pending, m_ack, m_rej, m_last, m_chk_r, m_chk_c;
    int win_mode;
    bit do_compare;
    int in_rst, in_ng, in_mv, in_r, in_c, in_win;

    typedef struct {
        logic       ng;
        logic       mv;
        logic [3:0] r;
        logic [3:0] c;
        logic       e_ready;
        logic       e_ack;
        logic       e_rej;
        logic       e_turn;
        logic [7:0] e_count;
        logic       e_b112;
    } vec_t;

    vec_t tbl[6];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [CELLS-1:0] act, input logic [CELLS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CELLS-1:0] board_of(input int p);
        logic [CELLS-1:0] b;
        b = '0;
        for (int i = 0; i < CELLS; i++) b[i] = (occ[i] == p);
        return b;
    endfunction

    function automatic bit five(input int r, input int c, input int p);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int n = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int rr = r + s * dr[d];
                int cc = c + s * dc[d];
                while (rr >= 0 && rr < N && cc >= 0 && cc < N && occ[rr * N + cc] == p) begin
                    n++;
                    rr += s * dr[d];
                    cc += s * dc[d];
                end
            end
            if (n >= 5) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) occ[i] = 0;
        m_turn = 0; m_count = 0; m_over = 0; m_winner = 0; m_pending = 0;
        m_ack = 0; m_rej = 0; m_last = 0; m_chk_r = 0; m_chk_c = 0;
    endtask

    task automatic model_step();
        m_ack = 0;
        m_rej = 0;
        if (in_rst != 0 || in_ng != 0) begin
            model_reset();
        end else if (m_pending != 0) begin
            m_pending = 0;
            if (in_win != 0) begin
                m_over = 1;
                m_winner = (m_turn == 0) ? 1 : 2;
            end else if (m_count == CELLS) begin
                m_over = 1;
                m_winner = 3;
            end else begin
                m_turn = 1 - m_turn;
            end
        end else if (m_over == 0 && in_mv != 0) begin
            if (in_r < N && in_c < N && occ[in_r * N + in_c] == 0) begin
                occ[in_r * N + in_c] = m_turn + 1;
                m_count++;
                m_chk_r = in_r;
                m_chk_c = in_c;
                m_last = m_turn + 1;
                m_pending = 1;
                m_ack = 1;
            end else begin
                m_rej = 1;
            end
        end
    endtask

    task automatic compare_all();
        int exp_ready;
        exp_ready = (m_over == 0 && m_pending == 0 && in_ng == 0) ? 1 : 0;
        check_val("move_ready", 32'(move_ready), 32'(exp_ready));
        check_val("move_ack", 32'(move_ack), 32'(m_ack));
        check_val("move_reject", 32'(move_reject), 32'(m_rej));
        check_val("turn", 32'(turn), 32'(m_turn));
        check_val("move_count", 32'(move_count), 32'(m_count));
        check_val("game_over", 32'(game_over), 32'(m_over));
        check_val("winner", 32'(winner), 32'(m_winner));
        check_val("chk_row", 32'(chk_row), 32'(m_chk_r));
        check_val("chk_col", 32'(chk_col), 32'(m_chk_c));
        check_vec("board_black", board_black, board_of(1));
        check_vec("board_white", board_white, board_of(2));
        check_vec("chk_board", chk_board, board_of(m_last == 2 ? 2 : 1));
    endtask

    // Drives one cycle's inputs, plays the win checkers, and compares against the model.
    task automatic drive(input int ng, input int mv, input int r, input int c, input int rs);
        in_rst = rs; in_ng = ng; in_mv = mv; in_r = r; in_c = c;
        rst = 1'(rs);
        new_game = 1'(ng);
        move_valid = 1'(mv);
        move_row = 4'(r);
        move_col = 4'(c);
        if (m_pending != 0) begin
            case (win_mode)
                0: in_win = int'(five(m_chk_r, m_chk_c, m_turn + 1));
                1: in_win = 0;
                2: in_win = 1;
                default: in_win = (five(m_chk_r, m_chk_c, m_turn + 1) || $urandom_range(0, 24) == 0) ? 1 : 0;
            endcase
        end else begin
            in_win = int'($urandom_range(0, 1));
        end
        chk_win = 1'(in_win);
        #1;
        if (do_compare) compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int ng, input int mv, input int r, input int c, input int rs);
        drive(ng, mv, r, c, rs);
        advance();
    endtask

    task automatic do_reset();
        apply_stimulus(0, 0, 0, 0, 1);
    endtask

    task automatic place(input int r, input int c);
        apply_stimulus(0, 1, r, c, 0);
        apply_stimulus(0, 0, 0, 0, 0);
    endtask

    task automatic fill_board(input int last_mode);
        do_reset();
        win_mode = 1;
        for (int i = 0; i < CELLS; i++) begin
            if (i == CELLS - 1) win_mode = last_mode;
            place(i / N, i % N);
        end
    endtask

    initial begin
        rst = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_row = 4'd0; move_col = 4'd0;
        chk_win = 1'b0;
        win_mode = 0;
        do_compare = 1'b0;
        in_rst = 1; in_ng = 0; in_mv = 0; in_r = 0; in_c = 0; in_win = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        do_compare = 1'b1;

        // Legal move at the centre, then an occupied replay and an off-board row.
        tbl[0] = '{1'b0, 1'b1, 4'd7,  4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 4'd7,  4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 4'd15, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 4'd0,  4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(int'(tbl[i].ng), int'(tbl[i].mv), int'(tbl[i].r), int'(tbl[i].c), 0);
            check_val("tbl_ready", 32'(move_ready), 32'(tbl[i].e_ready));
            check_val("tbl_ack", 32'(move_ack), 32'(tbl[i].e_ack));
            check_val("tbl_reject", 32'(move_reject), 32'(tbl[i].e_rej));
            check_val("tbl_turn", 32'(turn), 32'(tbl[i].e_turn));
            check_val("tbl_count", 32'(move_count), 32'(tbl[i].e_count));
            check_val("tbl_black112", 32'(board_black[112]), 32'(tbl[i].e_b112));
            advance();
        end

        // Black completes the main diagonal on the ninth move.
        do_reset();
        win_mode = 0;
        place(0, 0); place(10, 0); place(1, 1); place(10, 2); place(2, 2);
        place(10, 4); place(3, 3); place(10, 6); place(4, 4);
        check_val("diag_game_over", 32'(game_over), 32'd1);
        check_val("diag_winner", 32'(winner), 32'd1);
        apply_stimulus(0, 1, 5, 5, 0);
        drive(0, 0, 0, 0, 0);
        check_val("over_no_ack", 32'(move_ack), 32'd0);
        check_val("over_no_reject", 32'(move_reject), 32'd0);
        check_val("over_ready", 32'(move_ready), 32'd0);
        advance();

        // Reset from OVER.
        apply_stimulus(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check_val("rst_over_game_over", 32'(game_over), 32'd0);
        check_val("rst_over_winner", 32'(winner), 32'd0);
        check_val("rst_over_count", 32'(move_count), 32'd0);
        check_vec("rst_over_black", board_black, '0);
        check_vec("rst_over_white", board_white, '0);
        check_val("rst_over_ready", 32'(move_ready), 32'd1);
        advance();

        // Full board with no win is a draw; a win on the last cell beats the draw.
        fill_board(1);
        check_val("draw_game_over", 32'(game_over), 32'd1);
        check_val("draw_winner", 32'(winner), 32'd3);
        check_val("draw_count", 32'(move_count), 32'd225);
        fill_board(2);
        check_val("last_win_winner", 32'(winner), 32'd1);

        // new_game beats a simultaneous move, and cancels a pending win sample.
        do_reset();
        win_mode = 0;
        place(7, 7);
        place(7, 8);
        drive(1, 1, 0, 0, 0);
        check_val("ng_move_ready", 32'(move_ready), 32'd0);
        advance();
        drive(0, 0, 0, 0, 0);
        check_val("ng_move_ack", 32'(move_ack), 32'd0);
        check_val("ng_move_reject", 32'(move_reject), 32'd0);
        check_val("ng_move_count", 32'(move_count), 32'd0);
        check_vec("ng_move_black", board_black, '0);
        advance();
        apply_stimulus(0, 1, 3, 3, 0);
        win_mode = 2;
        apply_stimulus(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_val("ng_check_winner", 32'(winner), 32'd0);
        check_val("ng_check_over", 32'(game_over), 32'd0);
        check_val("ng_check_ack", 32'(move_ack), 32'd0);
        check_val("ng_check_count", 32'(move_count), 32'd0);
        advance();

        // Randomized play against the model.
        do_reset();
        win_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus(($urandom_range(0, 59) == 0) ? 1 : 0,
                           ($urandom_range(0, 2) != 0) ? 1 : 0,
                           int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)),
                           ($urandom_range(0, 499) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
